// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: tag-write buffer payload and tag SRAM write data.
package vector_cache_pkg;

    localparam int TAG_WIDTH   = 8;
    localparam int INDEX_WIDTH = 4;
    localparam int WAY_NUM     = 4;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [TAG_WIDTH-1:0]   tag;
        logic [WAY_NUM-1:0]     way_oh;
    } wr_buf_pld_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } tag_ram_wdata_t;

endpackage

// File: rtl/vec_cache_tag_wr_ctrl_if.sv
// Request-side handshakes of the tag write controller: tag-write entries and tag lookups.
interface vec_cache_tag_wr_ctrl_if;
    import vector_cache_pkg::*;

    logic                   tag_buf_vld;
    wr_buf_pld_t            tag_buf_pld;
    logic                   tag_buf_rdy;
    logic                   lookup_vld;
    logic [INDEX_WIDTH-1:0] lookup_index;
    logic                   lookup_rdy;

    modport master (
        output tag_buf_vld, tag_buf_pld, lookup_vld, lookup_index,
        input  tag_buf_rdy, lookup_rdy
    );

    modport slave (
        input  tag_buf_vld, tag_buf_pld, lookup_vld, lookup_index,
        output tag_buf_rdy, lookup_rdy
    );

endinterface

// File: rtl/vec_cache_tag_wr_fifo.sv
// Circular FIFO of pending tag writes; exposes every slot's valid bit and index
// so the controller can detect lookups that would read a stale tag.
module vec_cache_tag_wr_fifo
    import vector_cache_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  wr_buf_pld_t                       push_pld,
    input  logic                              pop,
    output wr_buf_pld_t                       head_pld,
    output logic [$clog2(DEPTH):0]            count,
    output logic [DEPTH-1:0]                  ent_vld,
    output logic [DEPTH-1:0][INDEX_WIDTH-1:0] ent_index
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_buf_pld_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    // Push never targets the head slot while it is being popped, since push at full is impossible.
    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_pld;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_index[i] = mem_q[i].index;
    end

    assign ent_vld  = vld_q;
    assign head_pld = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/vec_cache_tag_wr_ctrl.sv
// Tag SRAM port arbiter: queued tag writes versus lookups, with a write starvation
// limit and a stall for lookups that hit an index still waiting to be written.
module vec_cache_tag_wr_ctrl
    import vector_cache_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    vec_cache_tag_wr_ctrl_if.slave    bus,
    output logic                      tag_ram_en,
    output logic                      tag_ram_wr,
    output logic [INDEX_WIDTH-1:0]    tag_ram_addr,
    output logic [WAY_NUM-1:0]        tag_ram_way_en,
    output tag_ram_wdata_t            tag_ram_wdata,
    output logic                      wr_done_vld,
    output logic [INDEX_WIDTH-1:0]    wr_done_index,
    output logic [WAY_NUM-1:0]        wr_done_way_oh
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    wr_buf_pld_t                            head_pld;
    logic [CW-1:0]                          count;
    logic [FIFO_DEPTH-1:0]                  ent_vld;
    logic [FIFO_DEPTH-1:0][INDEX_WIDTH-1:0] ent_index;

    logic empty, full, push, hz, wg, lookup_rdy;
    logic [SW-1:0]          starve_cnt_q, starve_cnt_d;
    logic                   wr_done_vld_q, wr_done_vld_d;
    logic [INDEX_WIDTH-1:0] wr_done_index_q, wr_done_index_d;
    logic [WAY_NUM-1:0]     wr_done_way_oh_q, wr_done_way_oh_d;

    vec_cache_tag_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pld  (bus.tag_buf_pld),
        .pop       (wg),
        .head_pld  (head_pld),
        .count     (count),
        .ent_vld   (ent_vld),
        .ent_index (ent_index)
    );

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign push  = bus.tag_buf_vld && !full;

    // The entry being pushed this cycle is not yet visible in the queue, so compare it too.
    always_comb begin
        hz = 1'b0;
        if (bus.lookup_vld) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_vld[i] && (ent_index[i] == bus.lookup_index)) begin
                    hz = 1'b1;
                end
            end
            if (push && (bus.tag_buf_pld.index == bus.lookup_index)) begin
                hz = 1'b1;
            end
        end
    end

    assign wg         = !empty && (!bus.lookup_vld || hz || full || (starve_cnt_q == STARVE_C));
    assign lookup_rdy = rst_n && bus.lookup_vld && !hz && !wg;

    assign bus.tag_buf_rdy = !full;
    assign bus.lookup_rdy  = lookup_rdy;

    always_comb begin
        tag_ram_en     = 1'b0;
        tag_ram_wr     = 1'b0;
        tag_ram_addr   = '0;
        tag_ram_way_en = '0;
        tag_ram_wdata  = '0;
        if (wg) begin
            tag_ram_en          = 1'b1;
            tag_ram_wr          = 1'b1;
            tag_ram_addr        = head_pld.index;
            tag_ram_way_en      = head_pld.way_oh;
            tag_ram_wdata.valid = 1'b1;
            tag_ram_wdata.tag   = head_pld.tag;
        end else if (lookup_rdy) begin
            tag_ram_en     = 1'b1;
            tag_ram_addr   = bus.lookup_index;
            tag_ram_way_en = '1;
        end
    end

    always_comb begin
        starve_cnt_d     = starve_cnt_q;
        wr_done_vld_d    = wg;
        wr_done_index_d  = '0;
        wr_done_way_oh_d = '0;
        if (wg || empty) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (wg) begin
            wr_done_index_d  = head_pld.index;
            wr_done_way_oh_d = head_pld.way_oh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q     <= '0;
            wr_done_vld_q    <= 1'b0;
            wr_done_index_q  <= '0;
            wr_done_way_oh_q <= '0;
        end else begin
            starve_cnt_q     <= starve_cnt_d;
            wr_done_vld_q    <= wr_done_vld_d;
            wr_done_index_q  <= wr_done_index_d;
            wr_done_way_oh_q <= wr_done_way_oh_d;
        end
    end

    assign wr_done_vld    = wr_done_vld_q;
    assign wr_done_index  = wr_done_index_q;
    assign wr_done_way_oh = wr_done_way_oh_q;

endmodule

// File: doc/vec_cache_tag_wr_ctrl.md
# vec_cache_tag_wr_ctrl

Downstream consumer of the write tag buffer: accepts `wr_buf_pld_t` entries (index, tag, evict way one-hot) over a valid/ready handshake and queues them. It arbitrates the single-port tag SRAM between queued tag writes and incoming tag lookups, with a starvation limit on writes. It also stalls any lookup whose index matches a pending write, so a lookup never reads a stale tag.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: number of pending tag-write entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive cycles a non-empty queue may lose arbitration before a write is forced.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tag_buf_vld`  in  1: upstream entry valid.
- `tag_buf_pld`  in  wr_buf_pld_t: {index, tag, way_oh}.
- `tag_buf_rdy`  out  1: queue can accept an entry.
- `lookup_vld`  in  1: tag read request valid.
- `lookup_index`  in  INDEX_WIDTH: set to read.
- `lookup_rdy`  out  1: lookup granted the SRAM this cycle.
- `tag_ram_en`  out  1: SRAM access this cycle.
- `tag_ram_wr`  out  1: 1 = write, 0 = read.
- `tag_ram_addr`  out  INDEX_WIDTH: SRAM set address.
- `tag_ram_way_en`  out  WAY_NUM: per-way write enable; all ones on read.
- `tag_ram_wdata`  out  TAG_WIDTH+1: {valid=1, tag}.
- `wr_done_vld`  out  1: registered pulse one cycle after a write issues.
- `wr_done_index`  out  INDEX_WIDTH: index of the completed write.
- `wr_done_way_oh`  out  WAY_NUM: way of the completed write.

## Operation
- Queue: circular FIFO of `FIFO_DEPTH` entries. Pointers are `$clog2(FIFO_DEPTH)` bits with natural wrap, plus a count register of `$clog2(FIFO_DEPTH)+1` bits.
- `tag_buf_rdy = (count != FIFO_DEPTH)`. It depends on registered state only and does not look at a pop in the same cycle.
- Push when `tag_buf_vld && tag_buf_rdy`. A pushed entry is first eligible for write the cycle after the push. There is no bypass.
- Hazard: `hz = lookup_vld` and `lookup_index` equals the index of any valid queue entry, or of the entry being pushed this cycle.
- Write grant `wg = !empty && (!lookup_vld || hz || full || starve_cnt == STARVE_MAX)`.
- Lookup grant `lookup_rdy = lookup_vld && !hz && !wg`.
- When `wg` is set:
  - `tag_ram_en = 1`, `tag_ram_wr = 1`.
  - `addr`, `way_en` and `wdata` are driven from the head entry.
  - The head is popped in the same cycle.
- When `lookup_rdy` is set: `tag_ram_en = 1`, `tag_ram_wr = 0`, `addr = lookup_index`, `way_en` = all ones.
- Otherwise `tag_ram_en = 0`, and `addr`, `way_en` and `wdata` are 0.
- `starve_cnt`:
  - Cleared on `wg` or when the queue is empty.
  - Otherwise increments each cycle the queue is non-empty and `wg` is low.
  - Saturates at `STARVE_MAX`.
- The same-cycle push and pop count update is `count + push - pop`. Push at full cannot occur.
- `way_oh` must be one-hot. This is a protocol requirement, checked by bench assertion; the design does no checking.

## Timing
- Reset values:
  - `tag_buf_rdy = 1`, `lookup_rdy = 0`.
  - All `tag_ram_*` outputs 0.
  - `wr_done_*` outputs 0.
  - count, pointers and `starve_cnt` 0.
- SRAM control outputs are combinational from registered state and the current lookup inputs. Their latency is 0 cycles from the grant decision.
- Write latency: push at cycle N gives the earliest SRAM write at N+1 and `wr_done_vld` at N+2.
- Read data returns from the SRAM at the next edge. This block does not register or forward it.
- Reset asserted mid-operation: the queue is discarded and all outputs return to their reset values asynchronously. Pending writes are lost; upstream must also be reset.

## Structure
- `wr_buf_pld_t`, `TAG_WIDTH`, `INDEX_WIDTH` and `WAY_NUM` come from `vector_cache_pkg`.
- Add `tag_ram_wdata_t` ({valid, tag}) to the package.
- One sub-module: `vec_cache_tag_wr_fifo`, a generic `wr_buf_pld_t` FIFO. It exposes all entries' valid bits and indices for the hazard compare.
- Arbitration, the starvation counter and the `wr_done` register live in the top module.

## Test plan
- Reset then idle: all outputs at their reset values; `tag_buf_rdy = 1`.
- Single write, no lookups:
  - Push {index=5, tag=0x3A, way_oh=4'b0010} at cycle 1.
  - Cycle 2: `tag_ram_en = 1`, `wr = 1`, `addr = 5`, `way_en = 0010`, `wdata = {1, 0x3A}`.
  - Cycle 3: `wr_done_vld = 1` with `index = 5`.
- Hazard:
  - Queue holds index 7.
  - `lookup_index = 7` gives `lookup_rdy = 0` and the write issues.
  - Next cycle the same lookup gets `lookup_rdy = 1` with `addr = 7`, `wr = 0`.
- Starvation:
  - Queue holds one entry and lookups to index 1 are continuous.
  - The lookup wins for 4 cycles, then cycle 5 forces the write.
  - `lookup_rdy = 0` on that cycle and `starve_cnt` returns to 0.
- Full:
  - Push 2 entries while lookups hold the SRAM.
  - `tag_buf_rdy = 0` and the write is forced because the queue is full.
  - `tag_buf_rdy` returns to 1 the cycle after the pop.
  - Entries are written in FIFO order.
- Reset mid-operation: assert `rst_n = 0` with 2 queued entries. Outputs clear immediately; after release there are no writes and `wr_done_vld` never pulses.
